// File: rtl/tick_period_meter.sv
// Measures period and high time of a slow async tick in clock cycles.
// Optional input filter enabled by defining TICK_DEGLITCH_EN.
module tick_period_meter #(
  parameter int COUNTER_WIDTH   = 32,
  parameter int TIMEOUT_CYCLES  = 1_000_000,
  parameter int DEGLITCH_CYCLES = 3
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     tick_in,
  output logic [COUNTER_WIDTH-1:0] period,
  output logic [COUNTER_WIDTH-1:0] high_time,
  output logic                     period_valid,
  output logic                     locked,
  output logic                     timeout
);

  localparam logic [COUNTER_WIDTH-1:0] TMO =
    COUNTER_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [COUNTER_WIDTH-1:0] ONE =
    COUNTER_WIDTH'(1);

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic s1;
  logic s2;
  logic s3;
  logic lvl;
  logic rise;
  logic fall;
  logic at_tmo;
  logic [COUNTER_WIDTH-1:0] counter;

  // Two-flop synchronizer into the clock domain
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
    end
  end

`ifdef TICK_DEGLITCH_EN
  localparam int DW = $clog2(DEGLITCH_CYCLES + 1);
  localparam logic [DW-1:0] DLAST =
    DW'(DEGLITCH_CYCLES - 1);

  logic          filt;
  logic [DW-1:0] dg_cnt;

  // Accept a new level only after a run of differing samples
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      filt   <= 1'b0;
      dg_cnt <= '0;
    end else if (s2 == filt) begin
      dg_cnt <= '0;
    end else if (dg_cnt == DLAST) begin
      filt   <= s2;
      dg_cnt <= '0;
    end else begin
      dg_cnt <= dg_cnt + 1'b1;
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  // Delayed copy of the level for edge detection
  always_ff @(posedge clock) begin
    if (!reset_n) s3 <= 1'b0;
    else          s3 <= lvl;
  end

  assign rise   = lvl & ~s3;
  assign fall   = ~lvl & s3;
  assign at_tmo = (counter == TMO);

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= SEEK;
    else          state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      SEEK:    if (rise) state_nx = MEASURE;
      MEASURE,
      LOCKED: begin
        if (rise)        state_nx = LOCKED;
        else if (at_tmo) state_nx = SEEK;
      end
      default: state_nx = SEEK;
    endcase
  end

  // Counter and registered measurement outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      counter      <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (rise)
        counter <= ONE;
      else if (state != SEEK && !at_tmo)
        counter <= counter + ONE;
      if (state != SEEK) begin
        if (fall)
          high_time <= counter;
        if (rise) begin
          period       <= counter;
          period_valid <= 1'b1;
          locked       <= 1'b1;
          timeout      <= 1'b0;
        end else if (at_tmo) begin
          timeout <= 1'b1;
          locked  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter.
// Expectations follow the TICK_DEGLITCH_EN setting of the build.
module tb_tick_period_meter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        tick_in = 1'b0;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        period_valid;
  logic        locked;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;
  int pv_count = 0;
  int base = 0;
  logic [31:0] last_period = '0;
  logic [31:0] last_high = '0;

  tick_period_meter #(
    .COUNTER_WIDTH(32),
    .TIMEOUT_CYCLES(100),
    .DEGLITCH_CYCLES(3)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .tick_in(tick_in),
    .period(period),
    .high_time(high_time),
    .period_valid(period_valid),
    .locked(locked),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Record every pulse, sampled away from the active edge
  always @(negedge clock) begin
    if (period_valid === 1'b1) begin
      pv_count++;
      last_period = period;
      last_high   = high_time;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    repeat (n) begin
      @(negedge clock);
      tick_in = lvl;
    end
  endtask

  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  initial begin
    // Reset held while the tick toggles
    for (int i = 0; i < 5; i++) drive(i[0], 1);
    #1;
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_pv", 32'(pv_count), 0);

    @(negedge clock);
    reset_n = 1'b1;
    tick_in = 1'b0;

    // One rise only: nothing measured yet
    wave(5, 5, 1);
    #1;
    check("first_rise_pv", 32'(pv_count), 0);
    check("first_rise_lock", 32'(locked), 0);
    check("first_rise_per", period, 0);

    // Symmetric 5/5
    wave(5, 5, 4);
    #1;
    check("sym_pv", 32'(pv_count), 4);
    check("sym_period", last_period, 10);
    check("sym_high", last_high, 5);
    check("sym_locked", 32'(locked), 1);
    check("sym_timeout", 32'(timeout), 0);

    // Asymmetric 3/7
    base = pv_count;
    wave(3, 7, 3);
    #1;
    check("asym_pv", 32'(pv_count - base), 3);
    check("asym_period", last_period, 10);
    check("asym_high", last_high, 3);

    // Stall: about 88 cycles since detected rise
    drive(1'b0, 80);
    #1;
    check("stall_early_to", 32'(timeout), 0);
    check("stall_early_lk", 32'(locked), 1);
    drive(1'b0, 30);
    #1;
    check("stall_to", 32'(timeout), 1);
    check("stall_locked", 32'(locked), 0);
    check("stall_period", period, 10);
    check("stall_high", high_time, 3);

    // Resume after stall
    base = pv_count;
    wave(5, 5, 1);
    #1;
    check("resume1_pv", 32'(pv_count - base), 0);
    check("resume1_to", 32'(timeout), 1);
    wave(5, 5, 1);
    #1;
    check("resume2_pv", 32'(pv_count - base), 1);
    check("resume2_to", 32'(timeout), 0);
    check("resume2_lk", 32'(locked), 1);
    check("resume2_per", last_period, 10);

    // One-cycle reset while locked
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("mrst_period", period, 0);
    check("mrst_high", high_time, 0);
    check("mrst_locked", 32'(locked), 0);
    check("mrst_timeout", 32'(timeout), 0);
    base = pv_count;
    wave(5, 5, 1);
    #1;
    check("mrst_1rise_pv", 32'(pv_count - base), 0);
    wave(5, 5, 1);
    #1;
    check("mrst_relock_pv", 32'(pv_count - base), 1);
    check("mrst_relock_lk", 32'(locked), 1);

    // One-cycle high glitch, 13 cycles after last rise
    base = pv_count;
    drive(1'b0, 3);
    drive(1'b1, 1);
    drive(1'b0, 20);
    #1;
`ifdef TICK_DEGLITCH_EN
    check("glitch_pv", 32'(pv_count - base), 0);
    check("glitch_period", period, 10);
`else
    check("glitch_pv", 32'(pv_count - base), 1);
    check("glitch_period", period, 13);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
